// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage (with package types)
// Purpose  : RV32I decode as a single-entry registered pipeline stage with a
//            valid/ready handshake on both sides and a flush input.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            in_valid/in_ready     - fetch-side handshake
//            in_instr, in_pc       - instruction word and its address
//            flush                 - drop held and offered instructions
//            out_valid/out_ready   - execute-side handshake
//            alu_control, rs1, rs2, rd, imm, pc_out, alu_src_imm,
//            alu_src_pc, reg_write, mem_read, mem_write, branch, jump,
//            illegal               - registered decoded bundle
// Revision : 1.0 - initial release
// ============================================================================

package types;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_BEQ  = 4'd10,
        ALU_BNE  = 4'd11,
        ALU_BLT  = 4'd12,
        ALU_BGE  = 4'd13,
        ALU_BLTU = 4'd14,
        ALU_BGEU = 4'd15
    } alu_control_t;
endpackage

module decode_stage (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [31:0]          in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output types::alu_control_t  alu_control,
    output logic [4:0]           rs1,
    output logic [4:0]           rs2,
    output logic [4:0]           rd,
    output logic [31:0]          imm,
    output logic [31:0]          pc_out,
    output logic                 alu_src_imm,
    output logic                 alu_src_pc,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 branch,
    output logic                 jump,
    output logic                 illegal
);
    import types::*;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

    // ------------------------------------------------------------------
    // Field extraction and immediate formats
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_shamt;

    assign w_opcode    = in_instr[6:0];
    assign w_funct3    = in_instr[14:12];
    assign w_funct7    = in_instr[31:25];
    assign w_imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u     = {in_instr[31:12], 12'b0};
    assign w_imm_j     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_shamt = {27'b0, in_instr[24:20]};

    // funct3 to arithmetic operation; alt selects SUB/SRA
    function automatic alu_control_t f_arith(input logic [2:0] f3, input logic alt);
        alu_control_t v;
        case (f3)
            3'b000:  v = alt ? ALU_SUB : ALU_ADD;
            3'b001:  v = ALU_SLL;
            3'b010:  v = ALU_SLT;
            3'b011:  v = ALU_SLTU;
            3'b100:  v = ALU_XOR;
            3'b101:  v = alt ? ALU_SRA : ALU_SRL;
            3'b110:  v = ALU_OR;
            default: v = ALU_AND;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction. Illegal encodings
    // leave every field at its default (ALU_ADD, all flags low).
    // ------------------------------------------------------------------
    alu_control_t w_alu;
    logic [31:0]  w_imm;
    logic [4:0]   w_rs1;
    logic         w_src_imm, w_src_pc, w_reg_write, w_mem_read, w_mem_write;
    logic         w_branch, w_jump, w_illegal;

    always_comb begin
        w_alu       = ALU_ADD;
        w_imm       = 32'b0;
        w_rs1       = in_instr[19:15];
        w_src_imm   = 1'b0;
        w_src_pc    = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_illegal   = 1'b0;
        case (w_opcode)
            c_OPC_OP: begin
                if (w_funct7 != 7'h00 && w_funct7 != 7'h20) begin
                    w_illegal = 1'b1;
                end else if (w_funct7 == 7'h20 && w_funct3 != 3'b000 && w_funct3 != 3'b101) begin
                    w_illegal = 1'b1;
                end else begin
                    w_alu       = f_arith(w_funct3, w_funct7[5]);
                    w_reg_write = 1'b1;
                end
            end
            c_OPC_OP_IMM: begin
                // instr[30] only distinguishes SRAI from SRLI; elsewhere it is immediate data
                w_alu       = f_arith(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
                w_imm       = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? w_imm_shamt : w_imm_i;
                w_src_imm   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_imm    = w_imm_b;
                w_branch = 1'b1;
                case (w_funct3)
                    3'b000:  w_alu = ALU_BEQ;
                    3'b001:  w_alu = ALU_BNE;
                    3'b100:  w_alu = ALU_BLT;
                    3'b101:  w_alu = ALU_BGE;
                    3'b110:  w_alu = ALU_BLTU;
                    3'b111:  w_alu = ALU_BGEU;
                    default: begin
                        w_illegal = 1'b1;
                        w_imm     = 32'b0;
                        w_branch  = 1'b0;
                    end
                endcase
            end
            c_OPC_LOAD: begin
                w_imm       = w_imm_i;
                w_src_imm   = 1'b1;
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OPC_STORE: begin
                w_imm       = w_imm_s;
                w_src_imm   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OPC_LUI: begin
                w_imm       = w_imm_u;
                w_rs1       = 5'd0;
                w_src_imm   = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_imm       = w_imm_u;
                w_src_imm   = 1'b1;
                w_src_pc    = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OPC_JAL: begin
                w_imm       = w_imm_j;
                w_src_imm   = 1'b1;
                w_src_pc    = 1'b1;
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OPC_JALR: begin
                w_imm       = w_imm_i;
                w_src_imm   = 1'b1;
                w_jump      = 1'b1;
                w_reg_write = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake and output register
    // ------------------------------------------------------------------
    logic r_valid;
    logic w_accept;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    alu_control_t r_alu;
    logic [4:0]   r_rs1, r_rs2, r_rd;
    logic [31:0]  r_imm, r_pc;
    logic         r_src_imm, r_src_pc, r_reg_write, r_mem_read, r_mem_write;
    logic         r_branch, r_jump, r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_alu       <= ALU_ADD;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_imm       <= 32'b0;
            r_pc        <= 32'b0;
            r_src_imm   <= 1'b0;
            r_src_pc    <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            // Payload only moves on accept, so a stalled bundle stays bit-stable
            if (w_accept) begin
                r_alu       <= w_alu;
                r_rs1       <= w_rs1;
                r_rs2       <= in_instr[24:20];
                r_rd        <= in_instr[11:7];
                r_imm       <= w_imm;
                r_pc        <= in_pc;
                r_src_imm   <= w_src_imm;
                r_src_pc    <= w_src_pc;
                r_reg_write <= w_reg_write;
                r_mem_read  <= w_mem_read;
                r_mem_write <= w_mem_write;
                r_branch    <= w_branch;
                r_jump      <= w_jump;
                r_illegal   <= w_illegal;
            end
        end
    end

    assign out_valid   = r_valid;
    assign alu_control = r_alu;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign rd          = r_rd;
    assign imm         = r_imm;
    assign pc_out      = r_pc;
    assign alu_src_imm = r_src_imm;
    assign alu_src_pc  = r_src_pc;
    assign reg_write   = r_reg_write;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign branch      = r_branch;
    assign jump        = r_jump;
    assign illegal     = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Scoreboard bench for decode_stage. Accepted instructions are
//            decoded by a reference model into a queue; a monitor compares
//            the presented bundle with the queue head every cycle it is valid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import types::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;
    logic [31:0]  in_instr = 32'b0;
    logic [31:0]  in_pc = 32'b0;
    logic         in_ready, out_valid;
    alu_control_t alu_control;
    logic [4:0]   rs1, rs2, rd;
    logic [31:0]  imm, pc_out;
    logic         alu_src_imm, alu_src_pc, reg_write, mem_read, mem_write;
    logic         branch, jump, illegal;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .alu_control(alu_control), .rs1(rs1), .rs2(rs2),
        .rd(rd), .imm(imm), .pc_out(pc_out), .alu_src_imm(alu_src_imm),
        .alu_src_pc(alu_src_pc), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_control_t alu;
        logic [4:0]   rs1, rs2, rd;
        logic [31:0]  imm, pc;
        logic         src_imm, src_pc, rw, mr, mw, br, jp, ill;
        logic         chk_imm, chk_src;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic m_ready = 1'b1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference decode written from the ISA rules
    function automatic alu_control_t arith(input logic [2:0] f3, input logic alt);
        alu_control_t t[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        if (alt && f3 == 3'd0) return ALU_SUB;
        if (alt && f3 == 3'd5) return ALU_SRA;
        return t[f3];
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [31:0] iimm = 32'($signed(ins[31:20]));
        alu_control_t bt[8] = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        e.alu = ALU_ADD; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.imm = 32'b0; e.pc = pc;
        e.src_imm = 0; e.src_pc = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.jp = 0; e.ill = 0;
        e.chk_imm = 1; e.chk_src = 1;
        case (ins[6:0])
            7'b0110011: begin
                e.chk_imm = 0;
                if (!(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5))
                    e.ill = 1;
                else begin e.alu = arith(f3, f7 == 7'h20); e.rw = 1; end
            end
            7'b0010011: begin
                e.alu = arith(f3, f3 == 3'd5 && ins[30]);
                e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : iimm;
                e.src_imm = 1; e.rw = 1;
            end
            7'b1100011: begin
                if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1;
                else begin
                    e.alu = bt[f3]; e.br = 1;
                    e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                end
            end
            7'b0000011: begin e.imm = iimm; e.src_imm = 1; e.mr = 1; e.rw = 1; end
            7'b0100011: begin
                e.imm = 32'($signed({ins[31:25], ins[11:7]})); e.src_imm = 1; e.mw = 1;
            end
            7'b0110111: begin e.imm = ins & 32'hFFFFF000; e.src_imm = 1; e.rw = 1; e.rs1 = 5'd0; end
            7'b0010111: begin e.imm = ins & 32'hFFFFF000; e.src_imm = 1; e.src_pc = 1; e.rw = 1; end
            7'b1101111: begin
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                e.src_imm = 1; e.src_pc = 1; e.jp = 1; e.rw = 1;
            end
            7'b1100111: begin e.imm = iimm; e.src_imm = 1; e.jp = 1; e.rw = 1; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin e.chk_imm = 0; e.chk_src = 0; end
        return e;
    endfunction

    function automatic logic [127:0] pack_exp(input exp_t e);
        return {e.alu, e.rs1, e.rs2, e.rd, e.imm, e.pc, e.src_imm, e.src_pc,
                e.rw, e.mr, e.mw, e.br, e.jp, e.ill};
    endfunction

    // Fields the model leaves unconstrained are taken from the expectation
    function automatic logic [127:0] pack_dut(input exp_t e);
        return {alu_control, rs1, rs2, rd, (e.chk_imm ? imm : e.imm), pc_out,
                (e.chk_src ? alu_src_imm : e.src_imm), (e.chk_src ? alu_src_pc : e.src_pc),
                reg_write, mem_read, mem_write, branch, jump, illegal};
    endfunction

    // Monitor: compare whatever the DUT presents against the scoreboard head
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
            m_ready = (q.size() == 0) || out_ready;
            chk("in_ready", 128'(in_ready), 128'(m_ready));
            if (out_valid && q.size() != 0) begin
                chk("bundle", pack_dut(q[0]), pack_exp(q[0]));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    // Expectation producer: watches the fetch side just before the edge
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (flush) q.delete();
            else if (in_valid && m_ready) q.push_back(model(in_instr, in_pc));
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc[9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
                               7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        int s = $urandom_range(0, 11);
        logic [31:0] w = $urandom;
        if (s < 9) w[6:0] = opc[s];
        if (w[6:0] == 7'b0110011 || (w[6:0] == 7'b0010011 && $urandom_range(0, 1) == 1)) begin
            case ($urandom_range(0, 3))
                0: w[31:25] = 7'h00;
                1, 2: w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    logic [31:0] dir_tbl[7] = '{32'h40208133, 32'hFFF00093, 32'h4030D093, 32'h00208463,
                                32'h0000007F, 32'h02208133, 32'h00209463};

    initial begin
        logic fl;
        #2;
        chk("reset_outputs", {out_valid, alu_control, rs1, rs2, rd, imm, pc_out, alu_src_imm,
                              alu_src_pc, reg_write, mem_read, mem_write, branch, jump, illegal}, 128'd0);
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk); #1 rst_n = 1'b1;

        // add x2,x1,x2 at 0x100
        step(1, 32'h00208133, 32'h100, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        #2;
        chk("add_direct", {out_valid, alu_control, rs1, rs2, rd, reg_write, pc_out},
            {1'b1, ALU_ADD, 5'd1, 5'd2, 5'd2, 1'b1, 32'h100});

        // beq x1,x2,+8
        step(1, 32'h00208463, 32'h200, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        #2;
        chk("beq_direct", {out_valid, alu_control, imm, branch, reg_write},
            {1'b1, ALU_BEQ, 32'd8, 1'b1, 1'b0});

        // illegal opcode
        step(1, 32'h0000007F, 32'h300, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);
        #2;
        chk("illegal_direct", {out_valid, illegal, alu_control, reg_write, mem_read, mem_write, branch, jump},
            {1'b1, 1'b1, ALU_ADD, 5'b0});

        // Directed table, back to back
        for (int i = 0; i < 7; i++) step(1, dir_tbl[i], 32'h400 + 32'(i * 4), 1, 0);

        // Stall three cycles with a pending offer, then release
        step(1, 32'h00500093, 32'h500, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h00600113, 32'h504, 0, 0);
        step(1, 32'h00600113, 32'h504, 1, 0);
        step(1, 32'h00700193, 32'h508, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Flush while holding, offered instruction must vanish
        step(1, 32'h00800213, 32'h600, 0, 0);
        step(1, 32'h00900293, 32'h604, 0, 1);
        step(0, 32'h0, 32'h0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            fl = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFFFFFC,
                 fl ? 1'b0 : ($urandom_range(0, 9) < 7), fl);
        end

        // Reset in the middle of a stall
        step(1, 32'h00A00313, 32'h700, 1, 0);
        step(1, 32'h00B00393, 32'h704, 0, 0);
        step(1, 32'h00B00393, 32'h704, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midstall_reset", {out_valid, alu_control, rs1, rs2, rd, imm, pc_out, alu_src_imm,
                               alu_src_pc, reg_write, mem_read, mem_write, branch, jump, illegal}, 128'd0);
        chk("midstall_in_ready", 128'(in_ready), 128'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b1; in_instr = 32'h00C00413; in_pc = 32'h800; out_ready = 1'b1; flush = 1'b0;
        step(0, 32'h0, 32'h0, 1, 0);
        #2;
        chk("post_reset_accept", {out_valid, pc_out, rd}, {1'b1, 32'h800, 5'd8});

        for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0);
        @(posedge clk); #1;
        chk("drain_empty", 128'(q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
